// File: rtl/alu16_nibble_seq_if.sv
// alu16_nibble_seq_if: request/response handshake bundle for alu16_nibble_seq.
//   Request : in_valid, in_ready, in_a, in_b, in_op
//   Response: out_valid, out_ready, out_result, out_zero, out_carry, out_overflow
//   master = the producer/consumer (execute stage), slave = alu16_nibble_seq.
interface alu16_nibble_seq_if;
  localparam int unsigned DW = 16;

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [2:0]    in_op;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_result;
  logic          out_zero;
  logic          out_carry;
  logic          out_overflow;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_zero, out_carry, out_overflow
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_zero, out_carry, out_overflow
  );
endinterface

// File: rtl/alu16_nibble_seq.sv
// alu16_nibble_seq: 16-bit ALU front end that runs each operation nibble by
// nibble on an external 4-bit ALU with carry chaining.
//   clk, rst          : clock, synchronous active-high reset
//   bus (slave)       : request/response valid-ready handshakes
//   alu_a/alu_b/alu_c : nibble operands and function select to the ALU4
//   alu_cin           : carry-in to the ALU4
//   alu_result/alu_carry/alu_overflow : combinational ALU4 response
module alu16_nibble_seq (
  input  logic              clk,
  input  logic              rst,
  alu16_nibble_seq_if.slave bus,
  output logic [3:0]        alu_a,
  output logic [3:0]        alu_b,
  output logic [2:0]        alu_c,
  output logic              alu_cin,
  input  logic [3:0]        alu_result,
  input  logic              alu_carry,
  input  logic              alu_overflow
);
  localparam int unsigned NIBBLES = 4;
  localparam int unsigned DW      = 4 * NIBBLES;
  localparam int unsigned NW      = $clog2(NIBBLES);
  localparam logic [NW-1:0] LAST_NIB = NW'(NIBBLES - 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e        state_q;
  logic [DW-1:0] a_q, b_q, sum_q;
  logic [2:0]    op_q;
  logic [NW-1:0] n_q;
  logic          in_ready_q, out_valid_q, out_zero_q, out_carry_q, out_overflow_q;
  logic [DW-1:0] out_result_q;
  logic [3:0]    alu_a_q, alu_b_q;
  logic [2:0]    alu_c_q;
  logic          alu_cin_q;   // also serves as the inter-nibble carry register

  logic [DW-1:0] sum_d, res_d;
  logic [NW-1:0] n_nxt;
  logic          op_arith;

  // Arithmetic ops all run through the ALU adder with carry chaining.
  function automatic logic is_arith(input logic [2:0] op);
    return op inside {OP_ADD, OP_SUB, OP_SLT, OP_EQ};
  endfunction

  // sub/slt/eq are a + ~b + 1.
  function automatic logic is_subtract(input logic [2:0] op);
    return is_arith(op) && (op != OP_ADD);
  endfunction

  function automatic logic [3:0] nib(input logic [DW-1:0] w, input logic [NW-1:0] i);
    return w[{i, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] b_drive(input logic [2:0] op, input logic [3:0] b);
    return is_subtract(op) ? ~b : b;
  endfunction

  function automatic logic [2:0] c_drive(input logic [2:0] op);
    return is_arith(op) ? OP_ADD : op;
  endfunction

  // Merge the current ALU nibble into the running word and form the final result.
  always_comb begin
    op_arith = is_arith(op_q);
    n_nxt    = n_q + NW'(1);
    sum_d    = sum_q;
    sum_d[{n_q, 2'b00} +: 4] = alu_result;
    case (op_q)
      OP_SLT:  res_d = DW'(sum_d[DW-1] ^ alu_overflow);
      OP_EQ:   res_d = DW'(sum_d == '0);
      default: res_d = sum_d;
    endcase
  end

  // Sequencer: IDLE -> RUN (one nibble per cycle) -> DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      a_q            <= '0;
      b_q            <= '0;
      op_q           <= '0;
      n_q            <= '0;
      sum_q          <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_zero_q     <= 1'b0;
      out_carry_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_c_q        <= '0;
      alu_cin_q      <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            op_q       <= bus.in_op;
            n_q        <= '0;
            sum_q      <= '0;
            alu_a_q    <= bus.in_a[3:0];
            alu_b_q    <= b_drive(bus.in_op, bus.in_b[3:0]);
            alu_c_q    <= c_drive(bus.in_op);
            alu_cin_q  <= is_subtract(bus.in_op);
            in_ready_q <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          sum_q <= sum_d;
          if (n_q == LAST_NIB) begin
            out_valid_q    <= 1'b1;
            out_result_q   <= res_d;
            out_zero_q     <= (res_d == '0);
            out_carry_q    <= op_arith & alu_carry;
            out_overflow_q <= op_arith & alu_overflow;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_c_q        <= '0;
            alu_cin_q      <= 1'b0;
            state_q        <= S_DONE;
          end else begin
            n_q       <= n_nxt;
            alu_a_q   <= nib(a_q, n_nxt);
            alu_b_q   <= b_drive(op_q, nib(b_q, n_nxt));
            alu_cin_q <= op_arith & alu_carry;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_zero     = out_zero_q;
  assign bus.out_carry    = out_carry_q;
  assign bus.out_overflow = out_overflow_q;
  assign alu_a            = alu_a_q;
  assign alu_b            = alu_b_q;
  assign alu_c            = alu_c_q;
  assign alu_cin          = alu_cin_q;
endmodule

// File: tb/tb_alu16_nibble_seq.sv
// tb_alu16_nibble_seq: directed bench for alu16_nibble_seq with a behavioural
// ALU4 attached to the nibble port.
module tb_alu16_nibble_seq;
  logic       clk;
  logic       rst;
  logic [3:0] alu_a, alu_b, alu_result;
  logic [2:0] alu_c;
  logic       alu_cin, alu_carry, alu_overflow;
  logic [4:0] alu_sum;

  int tests_run = 0;
  int tests_failed = 0;
  int bad_alu_op = 0;

  alu16_nibble_seq_if bus();

  alu16_nibble_seq dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_c        (alu_c),
    .alu_cin      (alu_cin),
    .alu_result   (alu_result),
    .alu_carry    (alu_carry),
    .alu_overflow (alu_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU4.
  always_comb begin
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;
    alu_sum      = '0;
    case (alu_c)
      3'b000: begin
        alu_sum      = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0000, alu_cin};
        alu_result   = alu_sum[3:0];
        alu_carry    = alu_sum[4];
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_sum[3] != alu_a[3]);
      end
      3'b010:  alu_result = ~alu_a;
      3'b011:  alu_result = alu_a & alu_b;
      3'b100:  alu_result = alu_a | alu_b;
      3'b101:  alu_result = alu_a ^ alu_b;
      default: alu_result = '0;
    endcase
  end

  // The ALU must never be asked for sub/slt/eq directly.
  always @(posedge clk) begin
    if (alu_c == 3'b001 || alu_c == 3'b110 || alu_c == 3'b111) bad_alu_op++;
  end

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        c;
    logic        v;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs[NV];

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic wait_ready(input int idx);
    int k = 0;
    while (bus.in_ready !== 1'b1 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("in_ready_wait", idx, 16'(bus.in_ready), 16'h0001);
  endtask

  // Present a request, hold it over one edge, then scramble the inputs.
  task automatic do_accept(input int idx, input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    wait_ready(idx);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_op    = ~op;
    bus.in_a     = ~a;
    bus.in_b     = ~b;
    check("in_ready_after_accept", idx, 16'(bus.in_ready), 16'h0000);
  endtask

  // out_valid must first appear after the 4th edge following the accept edge.
  task automatic wait_done(input int idx);
    int e = 0;
    do begin
      @(posedge clk); #1;
      e++;
    end while (bus.out_valid !== 1'b1 && e < 20);
    check("latency_edges", idx, 16'(e), 16'd4);
  endtask

  task automatic check_out(input int idx, input logic [15:0] res, input logic z, input logic c, input logic v);
    check("result", idx, bus.out_result, res);
    check("flags_zcv", idx, 16'({bus.out_zero, bus.out_carry, bus.out_overflow}), 16'({z, c, v}));
  endtask

  task automatic handshake(input int idx);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("valid_ready_after_hs", idx, 16'({bus.out_valid, bus.in_ready}), 16'b01);
    check("alu_idle_drive", idx, 16'({alu_a, alu_b, alu_c, alu_cin}), 16'h0000);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{3'b000, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{3'b001, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'b110, 16'hFFFE, 16'h0003, 16'h0001, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'b110, 16'h8000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 1'b1};
    vecs[5]  = '{3'b111, 16'h1234, 16'h1234, 16'h0001, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{3'b111, 16'h1234, 16'h1235, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 16'hF0F0, 16'hFF00, 16'hF000, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b101, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b010, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b100, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{3'b000, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{3'b001, 16'h5000, 16'h3000, 16'h2000, 1'b0, 1'b1, 1'b0};
    vecs[13] = '{3'b110, 16'h0003, 16'hFFFE, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b1, 1'b1};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_ready_valid", 0, 16'({bus.in_ready, bus.out_valid}), 16'b10);
    check("rst_result", 0, bus.out_result, 16'h0000);
    check("rst_flags", 0, 16'({bus.out_zero, bus.out_carry, bus.out_overflow}), 16'h0000);
    check("rst_alu_drive", 0, 16'({alu_a, alu_b, alu_c, alu_cin}), 16'h0000);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      do_accept(i, vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(i);
      check_out(i, vecs[i].res, vecs[i].z, vecs[i].c, vecs[i].v);
      handshake(i);
    end

    // Backpressure, with a second request held high from RUN through DONE
    do_accept(100, 3'b000, 16'h1234, 16'h4321);
    bus.in_valid = 1'b1;
    bus.in_op    = 3'b101;
    bus.in_a     = 16'h00FF;
    bus.in_b     = 16'h0F0F;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("run_in_ready_low", 100 + k, 16'(bus.in_ready), 16'h0000);
    end
    @(posedge clk); #1;
    check("bp_valid_up", 100, 16'(bus.out_valid), 16'h0001);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("bp_valid_ready", 110 + k, 16'({bus.out_valid, bus.in_ready}), 16'b10);
      check_out(110 + k, 16'h5555, 1'b0, 1'b0, 1'b0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("bp_ready_back", 120, 16'(bus.in_ready), 16'h0001);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("second_accepted", 121, 16'(bus.in_ready), 16'h0000);
    wait_done(122);
    check_out(122, 16'h0FF0, 1'b0, 1'b0, 1'b0);
    handshake(122);

    // Reset mid-RUN at nibble 2, then a clean op
    do_accept(200, 3'b000, 16'hABCD, 16'h1234);
    repeat (2) begin
      @(posedge clk); #1;
    end
    // nibble 2: a=B, b=2, carry chained in from C+3+1
    check("nib2_drive", 200, 16'({alu_a, alu_b, alu_c, alu_cin}), 16'({4'hB, 4'h2, 3'b000, 1'b1}));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready_valid", 201, 16'({bus.in_ready, bus.out_valid}), 16'b10);
    check("abort_result", 201, bus.out_result, 16'h0000);
    repeat (5) @(posedge clk);
    #1;
    check("abort_no_output", 202, 16'(bus.out_valid), 16'h0000);
    do_accept(203, 3'b001, 16'h0100, 16'h0001);
    wait_done(203);
    check_out(203, 16'h00FF, 1'b0, 1'b1, 1'b0);
    handshake(203);

    check("forbidden_alu_op", 300, 16'(bad_alu_op), 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
